sdrd_sectorrd: RTL

Upstream stage of the FAT32 controller in the SD-read path. It accepts a sector access address and issues a single-block read (CMD17) through the byte-wide SPI engine. It collects the 512 data bytes and delivers them as eight 512-bit chunks on a valid-pulse interface that the FAT32 controller consumes directly. It also signals busy, done and error status back to the requester.

---
 rtl/sdrd_pkg.sv | 41 ++++
 rtl/sdrd_bytepack.sv | 60 ++++++
 rtl/sdrd_sectorrd.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sdrd_pkg.sv
// sdrd_pkg: types and constants for the SD single-block sector reader.
//   state_e       : sector-read FSM states
//   CMD17/START_TOKEN/DUMMY : SPI protocol bytes
//   SECTOR_BYTES/CHUNK_BYTES/CHUNKS/CMD_BYTES : transfer geometry
//   cmd_byte()    : byte idx (0..5) of the CMD17 frame for a 32-bit argument
package sdrd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_R1,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_END
  } state_e;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] DUMMY       = 8'hFF;

  localparam int SECTOR_BYTES = 512;
  localparam int CHUNK_BYTES  = 64;
  localparam int CHUNKS       = SECTOR_BYTES / CHUNK_BYTES;
  localparam int CMD_BYTES    = 6;

  // The trailing byte of the frame is sent as 0xFF; the card ignores the
  // CRC field in SPI mode once initialised.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx,
                                          input logic [31:0] arg);
    case (idx)
      3'd0:    cmd_byte = CMD17;
      3'd1:    cmd_byte = arg[31:24];
      3'd2:    cmd_byte = arg[23:16];
      3'd3:    cmd_byte = arg[15:8];
      3'd4:    cmd_byte = arg[7:0];
      default: cmd_byte = DUMMY;
    endcase
  endfunction

endpackage

// File: rtl/sdrd_bytepack.sv
// sdrd_bytepack: packs received sector bytes into 512-bit chunks.
//   CLK, RST_X     : clock, async active-low reset
//   clr_i          : restart byte/chunk counting for a new sector
//   byte_vld_i     : byte_i is a data byte to pack
//   byte_i         : received byte
//   prm_o          : last completed chunk, first byte in [511:504]
//   chunk_vld_o    : one-cycle pulse the cycle after a chunk completes
//   sector_end_o   : combinational, high with the 512th byte of the sector
module sdrd_bytepack
  import sdrd_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_X,
  input  logic         clr_i,
  input  logic         byte_vld_i,
  input  logic [7:0]   byte_i,
  output logic [511:0] prm_o,
  output logic         chunk_vld_o,
  output logic         sector_end_o
);

  // Only 63 bytes need holding: the 64th goes straight into the chunk
  // register together with the shifted contents.
  logic [503:0] sr_q;
  logic [511:0] prm_q;
  logic [5:0]   bcnt_q;
  logic [2:0]   chunk_q;
  logic         vld_q;
  logic         chunk_end;

  assign chunk_end    = byte_vld_i && (bcnt_q == 6'(CHUNK_BYTES - 1));
  assign sector_end_o = chunk_end && (chunk_q == 3'(CHUNKS - 1));

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      sr_q    <= '0;
      prm_q   <= '0;
      bcnt_q  <= '0;
      chunk_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= chunk_end;
      if (clr_i) begin
        bcnt_q  <= '0;
        chunk_q <= '0;
      end else if (byte_vld_i) begin
        sr_q   <= {sr_q[495:0], byte_i};
        bcnt_q <= bcnt_q + 6'd1;
        if (chunk_end) begin
          prm_q   <= {sr_q, byte_i};
          chunk_q <= chunk_q + 3'd1;
        end
      end
    end
  end

  assign prm_o       = prm_q;
  assign chunk_vld_o = vld_q;

endmodule

// File: rtl/sdrd_sectorrd.sv
// sdrd_sectorrd: CMD17 single-block SD read over a byte-wide SPI engine,
// delivering the sector as eight 512-bit chunks.
//   CLK, RST_X            : clock, async active-low reset
//   SPI_INIT              : card ready; dropping it aborts a read with error
//   ACCESS_REQ/ACCESS_ADR : request pulse and sector number
//   SPI_BUSY/SPI_DONE/SPI_RXD : byte engine status and received byte
//   SPI_TXSTART/SPI_TXD   : byte start strobe and byte to send
//   SPI_CS_X              : card select, low from CMD through CRC
//   FATIN_PRM/FATIN_VALID : chunk data and its one-cycle strobe
//   RD_BUSY/RD_DONE/RD_ERR: request status (RD_ERR sticky until next request)
// Build option: SDRD_BYTEADR_EN sends ACCESS_ADR<<9 (byte-addressed SDSC).
module sdrd_sectorrd
  import sdrd_pkg::*;
#(
  parameter int R1_TIMEOUT    = 8,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic         CLK,
  input  logic         RST_X,
  input  logic         SPI_INIT,
  input  logic         ACCESS_REQ,
  input  logic [31:0]  ACCESS_ADR,
  input  logic         SPI_BUSY,
  input  logic         SPI_DONE,
  input  logic [7:0]   SPI_RXD,
  output logic         SPI_TXSTART,
  output logic [7:0]   SPI_TXD,
  output logic         SPI_CS_X,
  output logic [511:0] FATIN_PRM,
  output logic         FATIN_VALID,
  output logic         RD_BUSY,
  output logic         RD_DONE,
  output logic         RD_ERR
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] adr_q;
  logic [31:0] cmd_arg;
  logic        wait_q;   // a byte is on the wire, next start waits for DONE
  logic        own_q;    // that byte was started in the current state
  logic        accept, abort, rx_ok, txstart, rd_done;
  logic        data_vld, sector_end;

`ifdef SDRD_BYTEADR_EN
  assign cmd_arg = {adr_q[22:0], 9'd0};
`else
  assign cmd_arg = adr_q;
`endif

  assign accept = (state_q == S_IDLE) && ACCESS_REQ && SPI_INIT && !SPI_BUSY;
  assign abort  = !SPI_INIT && (state_q inside {S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC});

  // A DONE for a byte launched before a state change (only possible on an
  // abort) must not be counted against the new state.
  assign rx_ok   = SPI_DONE && own_q;
  assign txstart = (state_q != S_IDLE) && !wait_q && !SPI_BUSY && !abort;

  assign data_vld = (state_q == S_DATA) && rx_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_done = 1'b0;
    if (rx_ok) cnt_d = cnt_q + 16'd1;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CMD;
          err_d   = 1'b0;
        end
      end
      S_CMD: begin
        if (rx_ok && cnt_q == 16'(CMD_BYTES - 1)) state_d = S_R1;
      end
      S_R1: begin
        if (rx_ok) begin
          if (SPI_RXD != DUMMY) begin
            if (SPI_RXD == 8'h00) begin
              state_d = S_TOKEN;
            end else begin
              err_d   = 1'b1;
              state_d = S_END;
            end
          end else if (cnt_q == 16'(R1_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_END;
          end
        end
      end
      S_TOKEN: begin
        if (rx_ok) begin
          if (SPI_RXD != DUMMY) begin
            if (SPI_RXD == START_TOKEN) begin
              state_d = S_DATA;
            end else begin
              err_d   = 1'b1;
              state_d = S_END;
            end
          end else if (cnt_q == 16'(TOKEN_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_END;
          end
        end
      end
      S_DATA: begin
        if (sector_end) state_d = S_CRC;
      end
      S_CRC: begin
        if (rx_ok && cnt_q == 16'd1) state_d = S_END;
      end
      S_END: begin
        if (rx_ok) begin
          state_d = S_IDLE;
          rd_done = !err_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      err_d   = 1'b1;
      state_d = S_END;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      wait_q  <= 1'b0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) adr_q <= ACCESS_ADR;
      if (txstart)       wait_q <= 1'b1;
      else if (SPI_DONE) wait_q <= 1'b0;
      if (state_d != state_q) own_q <= 1'b0;
      else if (txstart)       own_q <= 1'b1;
      else if (SPI_DONE)      own_q <= 1'b0;
    end
  end

  sdrd_bytepack u_pack (
    .CLK          (CLK),
    .RST_X        (RST_X),
    .clr_i        (accept),
    .byte_vld_i   (data_vld),
    .byte_i       (SPI_RXD),
    .prm_o        (FATIN_PRM),
    .chunk_vld_o  (FATIN_VALID),
    .sector_end_o (sector_end)
  );

  assign SPI_TXSTART = txstart;
  assign SPI_TXD     = (state_q == S_CMD) ? cmd_byte(cnt_q[2:0], cmd_arg) : DUMMY;
  assign SPI_CS_X    = (state_q == S_IDLE) || (state_q == S_END);
  assign RD_BUSY     = (state_q != S_IDLE);
  assign RD_DONE     = rd_done;
  assign RD_ERR      = err_q;

endmodule
